// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the decode/operand-fetch stage.
// Holds the instruction-register field positions, the opcode constants the
// decoder needs to recognise, the MD/BS encodings and the packed control word
// handed from dof_decode to dof_pipe.
package cpu_pkg;

  // Field positions inside the 32-bit instruction register.
  localparam int OPC_MSB = 31;
  localparam int DA_MSB  = 24;
  localparam int AA_MSB  = 19;
  localparam int BA_MSB  = 14;
  localparam int IMM_W   = 15;

  // Opcodes the decoder treats specially. Bit 5 marks the immediate family;
  // JMR, BZ, BNZ and SLT share that bit but still read BBUS from a register.
  localparam logic [6:0] OP_NOP = 7'h00;
  localparam logic [6:0] OP_LD  = 7'h10;
  localparam logic [6:0] OP_ST  = 7'h11;
  localparam logic [6:0] OP_ANI = 7'h28;
  localparam logic [6:0] OP_ORI = 7'h29;
  localparam logic [6:0] OP_XRI = 7'h2A;
  localparam logic [6:0] OP_BZ  = 7'h60;
  localparam logic [6:0] OP_BNZ = 7'h61;
  localparam logic [6:0] OP_AIU = 7'h62;
  localparam logic [6:0] OP_JMP = 7'h64;
  localparam logic [6:0] OP_SIU = 7'h65;
  localparam logic [6:0] OP_JML = 7'h67;
  localparam logic [6:0] OP_JMR = 7'h70;
  localparam logic [6:0] OP_SLT = 7'h75;

  // Write-back source select.
  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_SLT = 2'b10;

  // Branch select.
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JUMP = 2'b10;
  localparam logic [1:0] BS_JREG = 2'b11;

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
  } ctrl_t;

endpackage

// File: rtl/dof_decode.sv
// dof_decode -- purely combinational instruction decoder.
// Ports:
//   opcode : IR[31:25]
//   imm    : IR[14:0], raw immediate field
//   ctrl   : decoded control word (RW, MD, BS, PS, MW, FS)
//   konst  : immediate extended to DW (zero- or sign-extended by opcode)
//   a_sel  : 1 = ABUS takes the PC (JML), 0 = register operand
//   b_sel  : 1 = BBUS takes konst, 0 = register operand
module dof_decode
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [6:0]       opcode,
  input  logic [IMM_W-1:0] imm,
  output ctrl_t            ctrl,
  output logic [DW-1:0]    konst,
  output logic             a_sel,
  output logic             b_sel
);

  logic zero_ext;

  // Control word: FS is always the low opcode bits; the rest is a lookup.
  always_comb begin
    ctrl    = '0;
    ctrl.fs = opcode[4:0];
    ctrl.rw = 1'b1;
    ctrl.md = MD_ALU;
    ctrl.bs = BS_NONE;
    case (opcode)
      OP_NOP, OP_ST, OP_BZ, OP_BNZ, OP_JMP, OP_JMR: ctrl.rw = 1'b0;
      default: ;
    endcase
    case (opcode)
      OP_LD:   ctrl.md = MD_MEM;
      OP_SLT:  ctrl.md = MD_SLT;
      default: ;
    endcase
    case (opcode)
      OP_BZ, OP_BNZ:  ctrl.bs = BS_COND;
      OP_JMP, OP_JML: ctrl.bs = BS_JUMP;
      OP_JMR:         ctrl.bs = BS_JREG;
      default: ;
    endcase
    ctrl.mw = (opcode == OP_ST);
    ctrl.ps = (opcode == OP_BZ);
  end

  // Unsigned and logical immediates zero-extend; everything else sign-extends.
  assign zero_ext = (opcode == OP_AIU) || (opcode == OP_SIU) || (opcode == OP_ANI) ||
                    (opcode == OP_ORI) || (opcode == OP_XRI);
  assign konst    = zero_ext ? {{(DW-IMM_W){1'b0}}, imm}
                             : {{(DW-IMM_W){imm[IMM_W-1]}}, imm};

  assign a_sel = (opcode == OP_JML);
  assign b_sel = opcode[5] && (opcode != OP_JMR) && (opcode != OP_BZ) &&
                 (opcode != OP_BNZ) && (opcode != OP_SLT);

endmodule

// File: rtl/dof_pipe.sv
// dof_pipe -- decode/operand-fetch stage with EX/WB bypass, load-use hazard
// detection and the DOF->EX pipeline register.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, PCM1, IR   : incoming instruction and its PC-1
//   stall, flush         : downstream hold / kill requests
//   ADATA, BDATA         : register-file read data for AA / BA
//   ex_*, wb_*           : bypass sources from the EX and WB stages
//   AA, BA               : combinational register-file read addresses
//   hazard               : combinational load-use stall request to fetch
//   out_valid .. BBUS    : registered control word and operand buses
module dof_pipe
  import cpu_pkg::*;
#(
  parameter int DW     = 32,
  parameter int PCW    = 16,
  parameter int RAW    = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           stall,
  input  logic           flush,
  input  logic [PCW-1:0] PCM1,
  input  logic [31:0]    IR,
  input  logic [DW-1:0]  ADATA,
  input  logic [DW-1:0]  BDATA,
  input  logic           ex_rw,
  input  logic           wb_rw,
  input  logic [RAW-1:0] ex_da,
  input  logic [RAW-1:0] wb_da,
  input  logic [DW-1:0]  ex_data,
  input  logic [DW-1:0]  wb_data,
  output logic [RAW-1:0] AA,
  output logic [RAW-1:0] BA,
  output logic           hazard,
  output logic           out_valid,
  output logic           RW,
  output logic           PS,
  output logic           MW,
  output logic [RAW-1:0] DA,
  output logic [1:0]     MD,
  output logic [1:0]     BS,
  output logic [4:0]     FS,
  output logic [DW-1:0]  ABUS,
  output logic [DW-1:0]  BBUS
);

  logic [6:0]     opcode;
  logic [RAW-1:0] da_in;
  ctrl_t          ctrl;
  logic [DW-1:0]  konst;
  logic           a_sel;
  logic           b_sel;
  logic [DW-1:0]  a_op;
  logic [DW-1:0]  b_op;
  logic [DW-1:0]  abus_next;
  logic [DW-1:0]  bbus_next;

  assign opcode = IR[OPC_MSB -: 7];
  assign da_in  = IR[DA_MSB -: RAW];
  assign AA     = IR[AA_MSB -: RAW];
  assign BA     = IR[BA_MSB -: RAW];

  dof_decode #(.DW(DW)) u_decode (
    .opcode (opcode),
    .imm    (IR[IMM_W-1:0]),
    .ctrl   (ctrl),
    .konst  (konst),
    .a_sel  (a_sel),
    .b_sel  (b_sel)
  );

  // Register 0 is hardwired to zero, so it is never forwarded. EX is the
  // younger result and therefore wins over WB.
  function automatic logic [DW-1:0] pick_operand(
    input logic [RAW-1:0] addr,
    input logic [DW-1:0]  rf,
    input logic           erw,
    input logic [RAW-1:0] eda,
    input logic [DW-1:0]  edat,
    input logic           wrw,
    input logic [RAW-1:0] wda,
    input logic [DW-1:0]  wdat
  );
    if (addr == '0)                        return '0;
    else if (FWD_EN && erw && eda == addr) return edat;
    else if (FWD_EN && wrw && wda == addr) return wdat;
    else                                   return rf;
  endfunction

  always_comb begin
    a_op = pick_operand(AA, ADATA, ex_rw, ex_da, ex_data, wb_rw, wb_da, wb_data);
    b_op = pick_operand(BA, BDATA, ex_rw, ex_da, ex_data, wb_rw, wb_da, wb_data);
  end

  assign abus_next = a_sel ? {{(DW-PCW){1'b0}}, PCM1} : a_op;
  assign bbus_next = b_sel ? konst : b_op;

  // A load in EX cannot be bypassed; BA only matters when BBUS reads a register.
  assign hazard = in_valid && out_valid && (MD == MD_MEM) && (DA != '0) &&
                  ((DA == AA) || (!b_sel && (DA == BA)));

  // Pipeline register: flush beats stall beats hazard beats a normal load.
  // Bubbles clear only the fields that cause side effects downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      RW        <= 1'b0;
      MW        <= 1'b0;
      PS        <= 1'b0;
      MD        <= MD_ALU;
      BS        <= BS_NONE;
      FS        <= '0;
      DA        <= '0;
      ABUS      <= '0;
      BBUS      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      RW        <= 1'b0;
      MW        <= 1'b0;
      BS        <= BS_NONE;
    end else if (!stall) begin
      if (hazard) begin
        out_valid <= 1'b0;
        RW        <= 1'b0;
        MW        <= 1'b0;
        BS        <= BS_NONE;
      end else begin
        out_valid <= in_valid;
        RW        <= in_valid & ctrl.rw;
        MW        <= in_valid & ctrl.mw;
        BS        <= in_valid ? ctrl.bs : BS_NONE;
        PS        <= ctrl.ps;
        MD        <= ctrl.md;
        FS        <= ctrl.fs;
        DA        <= da_in;
        ABUS      <= abus_next;
        BBUS      <= bbus_next;
      end
    end
  end

endmodule
